// File: rtl/mem_bus_if.sv
// Pipeline-side request/response and external SRAM-style bus bundle for mem_bus_arbiter.
// master = the arbiter, slave = the pipeline plus memory side that drives it.
interface mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_ce_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [DATA_W-1:0] inst_data_o;
  logic              inst_ready_o;

  logic              data_ce_i;
  logic              data_we_i;
  logic [3:0]        data_sel_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_ready_o;

  logic              flush_i;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [3:0]        bus_sel_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;
  logic              bus_err_o;

  logic              stall_req_o;

  modport master (
    input  inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_sel_i, data_addr_i,
           data_wdata_i, flush_i, bus_rdata_i, bus_ack_i,
    output inst_data_o, inst_ready_o, data_rdata_o, data_ready_o, bus_req_o, bus_we_o,
           bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o, stall_req_o
  );

  modport slave (
    output inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_sel_i, data_addr_i,
           data_wdata_i, flush_i, bus_rdata_i, bus_ack_i,
    input  inst_data_o, inst_ready_o, data_rdata_o, data_ready_o, bus_req_o, bus_we_o,
           bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o, stall_req_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-style bus between instruction fetch and MEM-stage data access, data first.
// Optional bus timeout/abort is built when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      clk,
  input  logic      rst,
  mem_bus_if.master b
);
  typedef enum logic [1:0] {IDLE, DATA, INST, INST_DROP} state_t;
  state_t state;
  logic   timeout;

  assign b.stall_req_o = (b.data_ce_i & ~b.data_ready_o) | (b.inst_ce_i & ~b.inst_ready_o);

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] to_cnt;

  // Fires on the TIMEOUT_CYCLES-th busy cycle without ack; an ack in that cycle still wins.
  assign timeout = (state != IDLE) && !b.bus_ack_i && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      b.bus_err_o <= 1'b0;
    end else begin
      b.bus_err_o <= timeout;
      if (state == IDLE || timeout) to_cnt <= '0;
      else if (!b.bus_ack_i)        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign b.bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      b.bus_req_o    <= 1'b0;
      b.bus_we_o     <= 1'b0;
      b.bus_sel_o    <= '0;
      b.bus_addr_o   <= '0;
      b.bus_wdata_o  <= '0;
      b.inst_data_o  <= '0;
      b.inst_ready_o <= 1'b0;
      b.data_rdata_o <= '0;
      b.data_ready_o <= 1'b0;
    end else begin
      b.inst_ready_o <= 1'b0;
      b.data_ready_o <= 1'b0;
      unique case (state)
        IDLE: begin
          // A requester whose ready is high this cycle still holds ce; skip it to avoid a replay.
          if (b.data_ce_i && !b.data_ready_o) begin
            b.bus_req_o   <= 1'b1;
            b.bus_we_o    <= b.data_we_i;
            b.bus_sel_o   <= b.data_sel_i;
            b.bus_addr_o  <= b.data_addr_i;
            b.bus_wdata_o <= b.data_wdata_i;
            state         <= DATA;
          end else if (b.inst_ce_i && !b.inst_ready_o && !b.flush_i) begin
            b.bus_req_o   <= 1'b1;
            b.bus_we_o    <= 1'b0;
            b.bus_sel_o   <= 4'b1111;
            b.bus_addr_o  <= b.inst_addr_i;
            b.bus_wdata_o <= '0;
            state         <= INST;
          end
        end
        DATA: begin
          if (b.bus_ack_i || timeout) begin
            b.bus_req_o    <= 1'b0;
            b.data_ready_o <= 1'b1;
            if (timeout)         b.data_rdata_o <= '0;
            else if (!b.bus_we_o) b.data_rdata_o <= b.bus_rdata_i;
            state <= IDLE;
          end
        end
        INST: begin
          if (b.bus_ack_i || timeout) begin
            b.bus_req_o <= 1'b0;
            // A flush landing on the completing cycle still discards the word.
            if (!b.flush_i) begin
              b.inst_ready_o <= 1'b1;
              b.inst_data_o  <= timeout ? '0 : b.bus_rdata_i;
            end
            state <= IDLE;
          end else if (b.flush_i) begin
            state <= INST_DROP;
          end
        end
        INST_DROP: begin
          if (b.bus_ack_i || timeout) begin
            b.bus_req_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboarded bench for mem_bus_arbiter; expected ready payloads are queued at issue time.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();
  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .b(bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] dq[$];
  logic [31:0] iq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus_if.data_ready_o === 1'b1) begin
      if (dq.size() == 0) chk("data_spurious_ready", 32'd1, 32'd0);
      else                chk("data_rdata", bus_if.data_rdata_o, dq.pop_front());
    end
    if (bus_if.inst_ready_o === 1'b1) begin
      if (iq.size() == 0) chk("inst_spurious_ready", 32'd1, 32'd0);
      else                chk("inst_data", bus_if.inst_data_o, iq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr, input logic we,
                          input logic [3:0] sel, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (bus_if.bus_req_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_req"},   32'(bus_if.bus_req_o), 32'd1);
    chk({tag, "_addr"},  bus_if.bus_addr_o, addr);
    chk({tag, "_we"},    32'(bus_if.bus_we_o), 32'(we));
    chk({tag, "_sel"},   32'(bus_if.bus_sel_o), 32'(sel));
    chk({tag, "_wdata"}, bus_if.bus_wdata_o, wd);
  endtask

  // Called at a negedge; holds off dly cycles, then acks so it is sampled at the next edge.
  task automatic give_ack(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                          input int dly);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk({tag, "_hold_req"},  32'(bus_if.bus_req_o), 32'd1);
      chk({tag, "_hold_addr"}, bus_if.bus_addr_o, addr);
    end
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = rd;
    @(posedge clk); #1;
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = '0;
  endtask

  task automatic wait_data_ready(input string tag, input logic exp_stall);
    int n = 0;
    @(negedge clk);
    while (bus_if.data_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_dready"}, 32'(bus_if.data_ready_o), 32'd1);
    chk({tag, "_stall"},  32'(bus_if.stall_req_o), 32'(exp_stall));
    @(posedge clk); #1;
    bus_if.data_ce_i = 1'b0;
    bus_if.data_we_i = 1'b0;
    @(negedge clk);
    chk({tag, "_dready_pulse"}, 32'(bus_if.data_ready_o), 32'd0);
  endtask

  task automatic wait_inst_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus_if.inst_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_iready"}, 32'(bus_if.inst_ready_o), 32'd1);
    @(posedge clk); #1;
    bus_if.inst_ce_i = 1'b0;
    @(negedge clk);
    chk({tag, "_iready_pulse"}, 32'(bus_if.inst_ready_o), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus_if.inst_ce_i = 0; bus_if.inst_addr_i = '0;
    bus_if.data_ce_i = 0; bus_if.data_we_i = 0; bus_if.data_sel_i = 4'hF;
    bus_if.data_addr_i = '0; bus_if.data_wdata_i = '0; bus_if.flush_i = 0;
    bus_if.bus_rdata_i = '0; bus_if.bus_ack_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_req",    32'(bus_if.bus_req_o), 0);
    chk("rst_we",     32'(bus_if.bus_we_o), 0);
    chk("rst_sel",    32'(bus_if.bus_sel_o), 0);
    chk("rst_addr",   bus_if.bus_addr_o, 0);
    chk("rst_rdata",  bus_if.data_rdata_o, 0);
    chk("rst_idata",  bus_if.inst_data_o, 0);
    chk("rst_ready",  32'({bus_if.data_ready_o, bus_if.inst_ready_o}), 0);
    chk("rst_err",    32'(bus_if.bus_err_o), 0);
    chk("rst_stall",  32'(bus_if.stall_req_o), 0);

    // Load with a 3-cycle ack delay.
    step();
    bus_if.data_ce_i = 1; bus_if.data_we_i = 0; bus_if.data_sel_i = 4'hF;
    bus_if.data_addr_i = 32'h8000_1000; bus_if.data_wdata_i = '0;
    dq.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_stall_early", 32'(bus_if.stall_req_o), 1);
    wait_req("t1", 32'h8000_1000, 1'b0, 4'hF, 32'h0);
    give_ack("t1", 32'h8000_1000, 32'hDEAD_BEEF, 3);
    wait_data_ready("t1", 1'b0);

    // Simultaneous requests: data wins, fetch follows; earliest ack on the data side.
    step();
    bus_if.data_ce_i = 1; bus_if.data_addr_i = 32'h8000_2004;
    bus_if.inst_ce_i = 1; bus_if.inst_addr_i = 32'hBFC0_0000;
    dq.push_back(32'h1111_2222);
    iq.push_back(32'h0000_0013);
    wait_req("t2d", 32'h8000_2004, 1'b0, 4'hF, 32'h0);
    give_ack("t2d", 32'h8000_2004, 32'h1111_2222, 0);
    wait_data_ready("t2d", 1'b1);
    wait_req("t2i", 32'hBFC0_0000, 1'b0, 4'hF, 32'h0);
    give_ack("t2i", 32'hBFC0_0000, 32'h0000_0013, 1);
    wait_inst_ready("t2i");

    // Store: rdata must hold the previous load value.
    step();
    bus_if.data_ce_i = 1; bus_if.data_we_i = 1; bus_if.data_sel_i = 4'b0100;
    bus_if.data_addr_i = 32'h8000_3000; bus_if.data_wdata_i = 32'h00AB_0000;
    dq.push_back(32'h1111_2222);
    wait_req("t3", 32'h8000_3000, 1'b1, 4'b0100, 32'h00AB_0000);
    give_ack("t3", 32'h8000_3000, 32'hFFFF_FFFF, 2);
    wait_data_ready("t3", 1'b0);
    bus_if.data_sel_i = 4'hF; bus_if.data_wdata_i = '0;

    // Flush during a fetch: the late ack is swallowed.
    step();
    bus_if.inst_ce_i = 1; bus_if.inst_addr_i = 32'hBFC0_0004;
    wait_req("t4", 32'hBFC0_0004, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    bus_if.flush_i = 1; bus_if.inst_ce_i = 0;
    @(posedge clk); #1;
    bus_if.flush_i = 0;
    @(negedge clk);
    chk("t4_req_held", 32'(bus_if.bus_req_o), 1);
    give_ack("t4", 32'hBFC0_0004, 32'h1234_5678, 0);
    repeat (3) @(negedge clk);
    chk("t4_req_drop", 32'(bus_if.bus_req_o), 0);
    chk("t4_idata",    bus_if.inst_data_o, 32'h0000_0013);

    // FSM must be back in IDLE and serving normally.
    step();
    bus_if.data_ce_i = 1; bus_if.data_addr_i = 32'h8000_4000;
    dq.push_back(32'hCAFE_F00D);
    wait_req("t4b", 32'h8000_4000, 1'b0, 4'hF, 32'h0);
    give_ack("t4b", 32'h8000_4000, 32'hCAFE_F00D, 0);
    wait_data_ready("t4b", 1'b0);

`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: abort after TO busy cycles with zeroed read data.
    step();
    bus_if.data_ce_i = 1; bus_if.data_addr_i = 32'h8000_6000;
    dq.push_back(32'h0);
    wait_req("t6", 32'h8000_6000, 1'b0, 4'hF, 32'h0);
    n = 0;
    while (bus_if.bus_err_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t6_err",     32'(bus_if.bus_err_o), 1);
    chk("t6_cycles",  32'(n), 32'(TO));
    chk("t6_dready",  32'(bus_if.data_ready_o), 1);
    chk("t6_req",     32'(bus_if.bus_req_o), 0);
    @(posedge clk); #1;
    bus_if.data_ce_i = 0;
    @(negedge clk);
    chk("t6_err_pulse", 32'(bus_if.bus_err_o), 0);
`else
    // Without the timeout the FSM just keeps waiting for ack.
    step();
    bus_if.data_ce_i = 1; bus_if.data_addr_i = 32'h8000_6000;
    dq.push_back(32'h7777_7777);
    wait_req("t6", 32'h8000_6000, 1'b0, 4'hF, 32'h0);
    repeat (30) @(negedge clk);
    chk("t6_req_wait", 32'(bus_if.bus_req_o), 1);
    chk("t6_err",      32'(bus_if.bus_err_o), 0);
    give_ack("t6", 32'h8000_6000, 32'h7777_7777, 0);
    wait_data_ready("t6", 1'b0);
`endif

    // Reset mid-transaction, then a stray ack.
    step();
    bus_if.data_ce_i = 1; bus_if.data_addr_i = 32'h8000_5000;
    wait_req("t5", 32'h8000_5000, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    rst = 1; bus_if.data_ce_i = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5_req_rst",   32'(bus_if.bus_req_o), 0);
    chk("t5_rdata_rst", bus_if.data_rdata_o, 0);
    give_ack("t5", 32'h0, 32'h5555_5555, 0);
    repeat (3) @(negedge clk);
    chk("t5_req_after", 32'(bus_if.bus_req_o), 0);
    chk("t5_rdata_after", bus_if.data_rdata_o, 0);

    repeat (3) step();
    chk("dq_empty", 32'(dq.size()), 0);
    chk("iq_empty", 32'(iq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
